bg_mem_writer: RTL



---
 rtl/bg_mem_writer_pkg.sv | 25 ++
 rtl/bg_mem_writer_if.sv | 30 +++
 rtl/bg_mem_writer_packer.sv | 63 ++++++
 rtl/bg_mem_writer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bg_mem_writer_pkg.sv
// rtl/bg_mem_writer_pkg.sv - shared types, image constants and nibble ordering for the background writer
package bg_pkg;

    localparam int IMG_W_DEF  = 320;
    localparam int IMG_H_DEF  = 240;
    localparam int ADDR_W_DEF = 16;

    localparam int NPIX   = IMG_W_DEF * IMG_H_DEF;
    localparam int NBYTES = NPIX / 2;

    // Even pixel lands in bits [7:4]; the reader picks [3:0] when address bit 0 is set
    localparam bit HI_NIBBLE_EVEN = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FILL   = 2'd2,
        DONE   = 2'd3
    } bg_wr_state_t;

    function automatic logic [7:0] pack_pair(input logic [3:0] first_px, input logic [3:0] second_px);
        return HI_NIBBLE_EVEN ? {first_px, second_px} : {second_px, first_px};
    endfunction

endpackage

// File: rtl/bg_mem_writer_if.sv
// rtl/bg_mem_writer_if.sv - pixel stream, fill control and memory port A bundle of the background writer
interface bg_mem_writer_if
    import bg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              start;
    logic              px_valid;
    logic              px_ready;
    logic [3:0]        px_data;
    logic              fill_req;
    logic [3:0]        fill_idx;
    logic              busy;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;

    modport master (
        output start, px_valid, px_data, fill_req, fill_idx,
        input  px_ready, busy, done, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  start, px_valid, px_data, fill_req, fill_idx,
        output px_ready, busy, done, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/bg_mem_writer_packer.sv
// rtl/bg_mem_writer_packer.sv - bg_nibble_packer: pairs 4-bit pixels into registered bytes
module bg_nibble_packer
    import bg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       nib_valid_i,
    input  logic [3:0] nib_data_i,
    input  logic       fill_valid_i,
    input  logic [7:0] fill_byte_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    logic [3:0] hi_q, hi_d;
    logic       odd_q, odd_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;

    // Clear drops any half-built byte; a fill byte bypasses pairing; otherwise absorb one nibble
    always_comb begin
        hi_d    = hi_q;
        odd_d   = odd_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        if (clr_i) begin
            hi_d  = 4'h0;
            odd_d = 1'b0;
        end else if (fill_valid_i) begin
            byte_d  = fill_byte_i;
            valid_d = 1'b1;
        end else if (nib_valid_i) begin
            if (!odd_q) begin
                hi_d  = nib_data_i;
                odd_d = 1'b1;
            end else begin
                byte_d  = pack_pair(hi_q, nib_data_i);
                valid_d = 1'b1;
                odd_d   = 1'b0;
            end
        end
    end

    // Phase, pending nibble and output byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= 4'h0;
            odd_q   <= 1'b0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            odd_q   <= odd_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;

endmodule

// File: rtl/bg_mem_writer.sv
// rtl/bg_mem_writer.sv - packs a raster nibble stream (or a solid fill, BG_WRITER_FILL_EN) into background memory port A
module bg_mem_writer
    import bg_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic            clk,
    input logic            rst,
    bg_mem_writer_if.slave bus
);

    localparam int NPIX_L   = IMG_W * IMG_H;
    localparam int NBYTES_L = NPIX_L / 2;
    localparam int CNT_W    = $clog2(NPIX_L);

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NPIX_L - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES_L - 1);

    bg_wr_state_t state_q, state_d;

    // Pixel index while streaming, byte index while filling
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              px_ready_q, px_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hs;
    logic              pk_clr;
    logic              pk_fill;
    logic [7:0]        pk_fill_byte;
    logic [7:0]        pk_byte;
    logic              pk_valid;

`ifdef BG_WRITER_FILL_EN
    logic [3:0] fill_nib_q, fill_nib_d;
    assign pk_fill_byte = {fill_nib_q, fill_nib_q};
`else
    logic unused_fill;
    assign unused_fill  = ^{bus.fill_req, bus.fill_idx};
    assign pk_fill_byte = 8'h00;
`endif

    // A pixel transfer that coincides with start belongs to the aborted frame and is dropped
    assign hs = (state_q == STREAM) && px_ready_q && bus.px_valid && !bus.start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start outranks fill_req in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                end
`ifdef BG_WRITER_FILL_EN
                else if (bus.fill_req) begin
                    state_d = FILL;
                end
`endif
            end
            STREAM: begin
                if (bus.start) begin
                    state_d = STREAM;
                end else if (hs && (cnt_q == LAST_PIX)) begin
                    state_d = DONE;
                end
            end
`ifdef BG_WRITER_FILL_EN
            FILL: begin
                if (cnt_q == LAST_BYTE) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; busy covers the last write cycle, done follows it
    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pk_clr     = 1'b0;
        pk_fill    = 1'b0;
        px_ready_d = (state_d == STREAM);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == DONE);
`ifdef BG_WRITER_FILL_EN
        fill_nib_d = fill_nib_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    pk_clr = 1'b1;
                end
`ifdef BG_WRITER_FILL_EN
                else if (bus.fill_req) begin
                    cnt_d      = '0;
                    fill_nib_d = bus.fill_idx;
                end
`endif
            end
            STREAM: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    pk_clr = 1'b1;
                end else if (hs) begin
                    if (cnt_q[0]) begin
                        addr_d = ADDR_W'(cnt_q >> 1);
                    end
                    if (cnt_q != LAST_PIX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef BG_WRITER_FILL_EN
            FILL: begin
                pk_fill = 1'b1;
                addr_d  = ADDR_W'(cnt_q);
                if (cnt_q != LAST_BYTE) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Counter, address and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            px_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BG_WRITER_FILL_EN
            fill_nib_q <= 4'h0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            px_ready_q <= px_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BG_WRITER_FILL_EN
            fill_nib_q <= fill_nib_d;
`endif
        end
    end

    bg_nibble_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (pk_clr),
        .nib_valid_i  (hs),
        .nib_data_i   (bus.px_data),
        .fill_valid_i (pk_fill),
        .fill_byte_i  (pk_fill_byte),
        .byte_o       (pk_byte),
        .byte_valid_o (pk_valid)
    );

    assign bus.px_ready = px_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_we   = pk_valid;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = pk_byte;

endmodule
